vga_timing: RTL

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Drives the pixel coordinates (`x`, `y`) consumed by the tile renderer. Takes the renderer's RGB back and registers it to the VGA DAC pins with sync and blank signals delayed to match the renderer's latency. Also emits a once-per-frame strobe so game logic can update sprite and map state during vertical blank.

---
 rtl/vga_timing.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster timing on a 50 MHz clock with latency-matched DAC outputs.
// Optional build macro VGA_TEST_PATTERN_EN replaces renderer colour with eight vertical colour bars.
// Ports:
//    clk, reset            system clock, synchronous active-high reset
//    pix_en                pixel tick, high every second clk
//    x, y                  registered pixel coordinates to the renderer, 0 outside the active area
//    frame_start           one-clk pulse on the tick entering the first blanking line
//    r_in, g_in, b_in      renderer colour, valid PIPE_LAT ticks after its x/y
//    vga_r, vga_g, vga_b   DAC colour, 0 while blanked
//    vga_hs, vga_vs        active-low syncs
//    vga_blank_n           low during blanking
//    vga_sync_n            tied low
//    vga_clk               25 MHz DAC clock
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE_LAT = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic       pix_en,
   output logic [9:0] x,
   output logic [8:0] y,
   output logic       frame_start,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_sync_n,
   output logic       vga_clk
);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   logic                phase_q, phase_d;
   logic [9:0]          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d;
   logic [8:0]          y_q, y_d;
   logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, act_pipe_q, act_pipe_d;
   logic [7:0]          vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
   logic                vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d, blank_n_q, blank_n_d;
   logic                h_wrap, active, hs_raw, vs_raw, act_del;
   logic [7:0]          col_r, col_g, col_b;
`ifdef VGA_TEST_PATTERN_EN
   // Column index travels with the sync pipeline so the bars line up with blank_n.
   logic [9:0] hd_q [PIPE_LAT];
   logic [9:0] hd_d [PIPE_LAT];
   logic [2:0] bar;
   always_comb begin
      hd_d = hd_q;
      if (phase_q) begin
         hd_d[0] = h_cnt_q;
         for (int i = 1; i < PIPE_LAT; i++) hd_d[i] = hd_q[i-1];
      end
      bar = '0;
      for (int i = 1; i < 8; i++) bar = (hd_q[PIPE_LAT-1] >= 10'(i * (H_ACTIVE / 8))) ? bar + 3'd1 : bar;
      col_r = {8{bar[2]}};
      col_g = {8{bar[1]}};
      col_b = {8{bar[0]}};
   end
   always_ff @(posedge clk) hd_q <= reset ? '{default: '0} : hd_d;
`else
   always_comb begin
      col_r = r_in;
      col_g = g_in;
      col_b = b_in;
   end
`endif
   always_comb begin
      phase_d    = ~phase_q;
      h_wrap     = h_cnt_q == H_LAST;
      active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_raw     = !(h_cnt_q >= HS_BEG && h_cnt_q < HS_END);
      vs_raw     = !(v_cnt_q >= VS_BEG && v_cnt_q < VS_END);
      h_cnt_d    = !phase_q ? h_cnt_q : h_wrap ? '0 : h_cnt_q + 10'd1;
      v_cnt_d    = !(phase_q && h_wrap) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      x_d        = !phase_q ? x_q : active ? h_cnt_q : '0;
      y_d        = !phase_q ? y_q : active ? v_cnt_q[8:0] : '0;
      hs_pipe_d  = hs_pipe_q;
      vs_pipe_d  = vs_pipe_q;
      act_pipe_d = act_pipe_q;
      if (phase_q) begin
         hs_pipe_d[0]  = hs_raw;
         vs_pipe_d[0]  = vs_raw;
         act_pipe_d[0] = active;
         for (int i = 1; i < PIPE_LAT; i++) begin
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
            act_pipe_d[i] = act_pipe_q[i-1];
         end
      end
      act_del   = act_pipe_q[PIPE_LAT-1];
      vga_r_d   = !phase_q ? vga_r_q : act_del ? col_r : '0;
      vga_g_d   = !phase_q ? vga_g_q : act_del ? col_g : '0;
      vga_b_d   = !phase_q ? vga_b_q : act_del ? col_b : '0;
      vga_hs_d  = phase_q ? hs_pipe_q[PIPE_LAT-1] : vga_hs_q;
      vga_vs_d  = phase_q ? vs_pipe_q[PIPE_LAT-1] : vga_vs_q;
      blank_n_d = phase_q ? act_del : blank_n_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q    <= 1'b0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         hs_pipe_q  <= '1;
         vs_pipe_q  <= '1;
         act_pipe_q <= '0;
         vga_r_q    <= '0;
         vga_g_q    <= '0;
         vga_b_q    <= '0;
         vga_hs_q   <= 1'b1;
         vga_vs_q   <= 1'b1;
         blank_n_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         hs_pipe_q  <= hs_pipe_d;
         vs_pipe_q  <= vs_pipe_d;
         act_pipe_q <= act_pipe_d;
         vga_r_q    <= vga_r_d;
         vga_g_q    <= vga_g_d;
         vga_b_q    <= vga_b_d;
         vga_hs_q   <= vga_hs_d;
         vga_vs_q   <= vga_vs_d;
         blank_n_q  <= blank_n_d;
      end
   end
   assign pix_en      = phase_q;
   assign vga_clk     = phase_q;
   assign vga_sync_n  = 1'b0;
   assign frame_start = phase_q && (h_cnt_q == '0) && (v_cnt_q == V_ACT);
   assign x           = x_q;
   assign y           = y_q;
   assign vga_r       = vga_r_q;
   assign vga_g       = vga_g_q;
   assign vga_b       = vga_b_q;
   assign vga_hs      = vga_hs_q;
   assign vga_vs      = vga_vs_q;
   assign vga_blank_n = blank_n_q;
endmodule
